// File: rtl/ysyx_23060077_riscv_csr_file_if.sv
// CSR access bus between the execute stage (master) and the M-mode CSR file (slave).
interface ysyx_23060077_riscv_csr_file_if #(
  parameter int unsigned XLEN = 32
);
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_op,
    output csr_addr,
    output csr_wdata,
    input  csr_rdata,
    input  csr_illegal
  );

  modport slave (
    input  csr_op,
    input  csr_addr,
    input  csr_wdata,
    output csr_rdata,
    output csr_illegal
  );
endinterface

// File: rtl/ysyx_23060077_riscv_csr_file.sv
// M-mode CSR file with trap entry, mret and timer/external interrupt gating.
// Optional 64-bit mcycle/minstret counters are enabled by defining YSYX_CSR_COUNTER_EN.
module ysyx_23060077_riscv_csr_file #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] HARTID    = '0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_23060077_riscv_csr_file_if.slave csr_bus,
  input  logic                          trap_valid_i,
  input  logic [XLEN-1:0]               trap_cause_i,
  input  logic [XLEN-1:0]               trap_pc_i,
  input  logic [XLEN-1:0]               trap_tval_i,
  input  logic                          mret_i,
  input  logic                          instret_inc_i,
  input  logic                          irq_timer_i,
  input  logic                          irq_ext_i,
  output logic                          irq_req_o,
  output logic [XLEN-1:0]               irq_cause_o,
  output logic [XLEN-1:0]               trap_target_o,
  output logic [XLEN-1:0]               mepc_o
);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;
  localparam logic [11:0] AddrMip      = 12'h344;
  localparam logic [11:0] AddrMhartid  = 12'hF14;
`ifdef YSYX_CSR_COUNTER_EN
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMinstreth = 12'hB82;
`endif

  localparam logic [XLEN-1:0] MieMask     = XLEN'(12'h880);
  localparam logic [XLEN-1:0] IrqCauseExt = (XLEN'(1) << (XLEN - 1)) | XLEN'(11);
  localparam logic [XLEN-1:0] IrqCauseTmr = (XLEN'(1) << (XLEN - 1)) | XLEN'(7);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            mtip_q, meip_q;
  logic            irq_req_q, irq_req_d;
  logic [XLEN-1:0] irq_cause_q, irq_cause_d;

  logic [XLEN-1:0] mstatus_rd, mip_rd, csr_raw, csr_wval, irq_pending, trap_base;
  logic            csr_access, csr_impl, csr_ro, csr_ill, csr_we;

`ifdef YSYX_CSR_COUNTER_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`endif

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7] = mstatus_mpie_q;
    mstatus_rd[3] = mstatus_mie_q;
    mip_rd = '0;
    mip_rd[11] = meip_q;
    mip_rd[7] = mtip_q;
  end

  always_comb begin
    csr_raw  = '0;
    csr_impl = 1'b1;
    csr_ro   = 1'b0;
    case (csr_bus.csr_addr)
      AddrMstatus:   csr_raw = mstatus_rd;
      AddrMie:       csr_raw = mie_q;
      AddrMtvec:     csr_raw = mtvec_q;
      AddrMscratch:  csr_raw = mscratch_q;
      AddrMepc:      csr_raw = mepc_q;
      AddrMcause:    csr_raw = mcause_q;
      AddrMtval:     csr_raw = mtval_q;
      AddrMip: begin
        csr_raw = mip_rd;
        csr_ro  = 1'b1;
      end
      AddrMhartid: begin
        csr_raw = HARTID;
        csr_ro  = 1'b1;
      end
`ifdef YSYX_CSR_COUNTER_EN
      AddrMcycle:    csr_raw = XLEN'(mcycle_q[31:0]);
      AddrMcycleh:   csr_raw = XLEN'(mcycle_q[63:32]);
      AddrMinstret:  csr_raw = XLEN'(minstret_q[31:0]);
      AddrMinstreth: csr_raw = XLEN'(minstret_q[63:32]);
`endif
      default:       csr_impl = 1'b0;
    endcase
  end

  assign csr_access = (csr_bus.csr_op != 2'b00);
  assign csr_ill    = csr_access && (!csr_impl || csr_ro);
  // Trap and mret own the cycle; a concurrent CSR write is silently dropped.
  assign csr_we     = csr_access && !csr_ill && !trap_valid_i && !mret_i;

  always_comb begin
    csr_wval = csr_raw;
    case (csr_bus.csr_op)
      2'b01:   csr_wval = csr_bus.csr_wdata;
      2'b10:   csr_wval = csr_raw | csr_bus.csr_wdata;
      2'b11:   csr_wval = csr_raw & ~csr_bus.csr_wdata;
      default: csr_wval = csr_raw;
    endcase
  end

  assign csr_bus.csr_rdata   = csr_access ? csr_raw : '0;
  assign csr_bus.csr_illegal = csr_ill;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (trap_valid_i) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mepc_d         = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d       = trap_cause_i;
      mtval_d        = trap_tval_i;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_bus.csr_addr)
        AddrMstatus: begin
          mstatus_mie_d  = csr_wval[3];
          mstatus_mpie_d = csr_wval[7];
        end
        AddrMie:      mie_d      = csr_wval & MieMask;
        AddrMtvec:    mtvec_d    = {csr_wval[XLEN-1:2], 1'b0, csr_wval[0]};
        AddrMscratch: mscratch_d = csr_wval;
        AddrMepc:     mepc_d     = {csr_wval[XLEN-1:2], 2'b00};
        AddrMcause:   mcause_d   = csr_wval;
        AddrMtval:    mtval_d    = csr_wval;
        default: ;
      endcase
    end
  end

  // Interrupt request looks at the synchronised pending bits, so it lags the lines by two cycles.
  assign irq_pending = mie_q & mip_rd;

  always_comb begin
    irq_req_d   = !trap_valid_i && mstatus_mie_q && (|irq_pending);
    irq_cause_d = '0;
    if (irq_pending[11]) begin
      irq_cause_d = IrqCauseExt;
    end else if (irq_pending[7]) begin
      irq_cause_d = IrqCauseTmr;
    end
  end

  assign trap_base     = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_target_o = (mtvec_q[0] && trap_cause_i[XLEN-1]) ?
                         trap_base + {trap_cause_i[XLEN-3:0], 2'b00} : trap_base;
  assign mepc_o        = mepc_q;
  assign irq_req_o     = irq_req_q;
  assign irq_cause_o   = irq_cause_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= {MTVEC_RST[XLEN-1:2], 1'b0, MTVEC_RST[0]};
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mtip_q         <= 1'b0;
      meip_q         <= 1'b0;
      irq_req_q      <= 1'b0;
      irq_cause_q    <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mtip_q         <= irq_timer_i;
      meip_q         <= irq_ext_i;
      irq_req_q      <= irq_req_d;
      irq_cause_q    <= irq_cause_d;
    end
  end

`ifdef YSYX_CSR_COUNTER_EN
  // A write to either half replaces the increment for the whole 64-bit counter.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instret_inc_i};
    if (csr_we && csr_bus.csr_addr == AddrMcycle) begin
      mcycle_d = {mcycle_q[63:32], csr_wval[31:0]};
    end else if (csr_we && csr_bus.csr_addr == AddrMcycleh) begin
      mcycle_d = {csr_wval[31:0], mcycle_q[31:0]};
    end
    if (csr_we && csr_bus.csr_addr == AddrMinstret) begin
      minstret_d = {minstret_q[63:32], csr_wval[31:0]};
    end else if (csr_we && csr_bus.csr_addr == AddrMinstreth) begin
      minstret_d = {csr_wval[31:0], minstret_q[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{trap_cause_i[XLEN-2], instret_inc_i};

endmodule

// File: tb/tb_ysyx_23060077_riscv_csr_file.sv
// Self-checking bench for the CSR file: directed scenarios plus randomized traffic against a
// behavioural model of the architectural CSR state.
module tb_ysyx_23060077_riscv_csr_file;

  localparam logic [31:0] HART = 32'd5;
  localparam logic [31:0] MTVR = 32'h8000_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_valid, mret, instret_inc, irq_timer, irq_ext;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        irq_req;
  logic [31:0] irq_cause, trap_target, mepc;

  always #5 clk = ~clk;

  ysyx_23060077_riscv_csr_file_if #(.XLEN(32)) bus ();

  ysyx_23060077_riscv_csr_file #(
    .XLEN      (32),
    .HARTID    (HART),
    .MTVEC_RST (MTVR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_bus       (bus),
    .trap_valid_i  (trap_valid),
    .trap_cause_i  (trap_cause),
    .trap_pc_i     (trap_pc),
    .trap_tval_i   (trap_tval),
    .mret_i        (mret),
    .instret_inc_i (instret_inc),
    .irq_timer_i   (irq_timer),
    .irq_ext_i     (irq_ext),
    .irq_req_o     (irq_req),
    .irq_cause_o   (irq_cause),
    .trap_target_o (trap_target),
    .mepc_o        (mepc)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: architectural values as written; read masks applied on read.
  bit          m_mie, m_mpie, m_mtip, m_meip, m_irq;
  logic [31:0] m_mie_r, m_mtvec, m_scratch, m_mepc, m_mcause, m_mtval, m_irq_cause;
`ifdef YSYX_CSR_COUNTER_EN
  logic [63:0] m_cycle, m_instret;
`endif

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hF14: return 1;
`ifdef YSYX_CSR_COUNTER_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_value(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
      12'h304: return m_mie_r;
      12'h305: return m_mtvec & ~32'h2;
      12'h340: return m_scratch;
      12'h341: return m_mepc & ~32'h3;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return {20'd0, m_meip, 3'd0, m_mtip, 7'd0};
      12'hF14: return HART;
`ifdef YSYX_CSR_COUNTER_EN
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_illegal();
    return bus.csr_op != 2'b00 &&
           (!m_impl(bus.csr_addr) || bus.csr_addr == 12'h344 || bus.csr_addr == 12'hF14);
  endfunction

  function automatic logic [31:0] m_rdata();
    return (bus.csr_op == 2'b00) ? 32'd0 : m_value(bus.csr_addr);
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mtvec[0] && trap_cause[31]) return base + (trap_cause << 2);
    return base;
  endfunction

  task automatic model_step();
    logic [31:0] old, w;
    bit          we, pt, pe, nirq;
    if (!rst_n) begin
      m_mie = 0; m_mpie = 0; m_mtip = 0; m_meip = 0; m_irq = 0;
      m_mie_r = 0; m_mtvec = MTVR; m_scratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_irq_cause = 0;
`ifdef YSYX_CSR_COUNTER_EN
      m_cycle = 0; m_instret = 0;
`endif
      return;
    end
    old = m_value(bus.csr_addr);
    w = (bus.csr_op == 2'b01) ? bus.csr_wdata :
        (bus.csr_op == 2'b10) ? (old | bus.csr_wdata) : (old & ~bus.csr_wdata);
    we = bus.csr_op != 2'b00 && !m_illegal() && !trap_valid && !mret;
    pt = m_mtip && m_mie_r[7];
    pe = m_meip && m_mie_r[11];
    nirq = !trap_valid && m_mie && (pt || pe);
`ifdef YSYX_CSR_COUNTER_EN
    if (we && bus.csr_addr == 12'hB00) m_cycle[31:0] = w;
    else if (we && bus.csr_addr == 12'hB80) m_cycle[63:32] = w;
    else m_cycle = m_cycle + 1;
    if (we && bus.csr_addr == 12'hB02) m_instret[31:0] = w;
    else if (we && bus.csr_addr == 12'hB82) m_instret[63:32] = w;
    else m_instret = m_instret + 64'(instret_inc);
`endif
    if (trap_valid) begin
      m_mpie = m_mie; m_mie = 0;
      m_mepc = trap_pc; m_mcause = trap_cause; m_mtval = trap_tval;
    end else if (mret) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (we) begin
      case (bus.csr_addr)
        12'h300: begin m_mie = w[3]; m_mpie = w[7]; end
        12'h304: m_mie_r = w & 32'h880;
        12'h305: m_mtvec = w;
        12'h340: m_scratch = w;
        12'h341: m_mepc = w;
        12'h342: m_mcause = w;
        12'h343: m_mtval = w;
        default: ;
      endcase
    end
    m_irq = nirq;
    if (nirq) m_irq_cause = pe ? 32'h8000_000B : 32'h8000_0007;
    m_mtip = irq_timer;
    m_meip = irq_ext;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.csr_op = 2'b00; bus.csr_addr = 12'h0; bus.csr_wdata = 32'h0;
    trap_valid = 0; mret = 0; instret_inc = 0;
    trap_cause = 0; trap_pc = 0; trap_tval = 0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 0;
    csr(2'b01, 12'h340, 32'hFFFF_FFFF);
    trap_valid = 1; mret = 0; instret_inc = 1; irq_timer = 1; irq_ext = 1;
    trap_cause = 32'h8000_0003; trap_pc = 32'h1234; trap_tval = 32'h55;
    tick(); tick();
    rst_n = 1;
    trap_valid = 0; instret_inc = 0;
    csr(2'b10, 12'h300, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h1800) begin err_cnt++;
      $display("FAIL reset_mstatus got=%h exp=%h", bus.csr_rdata, 32'h1800); end
    csr(2'b10, 12'h305, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h8000_0001) begin err_cnt++;
      $display("FAIL reset_mtvec got=%h exp=%h", bus.csr_rdata, 32'h8000_0001); end
    csr(2'b10, 12'h340, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h0) begin err_cnt++;
      $display("FAIL reset_mscratch got=%h exp=0", bus.csr_rdata); end
    csr(2'b10, 12'h344, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h0) begin err_cnt++;
      $display("FAIL reset_mip got=%h exp=0", bus.csr_rdata); end
    csr(2'b10, 12'hF14, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== HART || bus.csr_illegal !== 1'b1) begin err_cnt++;
      $display("FAIL reset_mhartid got=%h/%b exp=%h/1", bus.csr_rdata, bus.csr_illegal, HART); end
    csr(2'b00, 12'h305, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h0) begin err_cnt++;
      $display("FAIL reset_noop_read got=%h exp=0", bus.csr_rdata); end
    vec_cnt++; if (irq_req !== 1'b0 || mepc !== 32'h0) begin err_cnt++;
      $display("FAIL reset_irq_mepc got=%b/%h exp=0/0", irq_req, mepc); end
    vec_cnt++; if (trap_target !== 32'h8000_000C) begin err_cnt++;
      $display("FAIL reset_target got=%h exp=%h", trap_target, 32'h8000_000C); end
    idle(); irq_timer = 0; irq_ext = 0;
    tick();
  endtask

  task automatic test_write_read();
    csr(2'b01, 12'h340, 32'hDEAD_BEEF); #1;
    vec_cnt++; if (bus.csr_illegal !== 1'b0) begin err_cnt++;
      $display("FAIL wr_illegal got=%b exp=0", bus.csr_illegal); end
    tick();
    csr(2'b10, 12'h340, 32'h1); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'hDEAD_BEEF) begin err_cnt++;
      $display("FAIL wr_readback got=%h exp=%h", bus.csr_rdata, 32'hDEAD_BEEF); end
    tick();
    csr(2'b11, 12'h340, 32'hFF); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'hDEAD_BEEF) begin err_cnt++;
      $display("FAIL wr_after_set got=%h exp=%h", bus.csr_rdata, 32'hDEAD_BEEF); end
    tick();
    csr(2'b10, 12'h340, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'hDEAD_BE00) begin err_cnt++;
      $display("FAIL wr_after_clear got=%h exp=%h", bus.csr_rdata, 32'hDEAD_BE00); end
    csr(2'b01, 12'h341, 32'h1234_5677); tick();
    csr(2'b10, 12'h341, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h1234_5674) begin err_cnt++;
      $display("FAIL wr_mepc_mask got=%h exp=%h", bus.csr_rdata, 32'h1234_5674); end
    idle(); tick();
  endtask

  task automatic test_trap_mret();
    csr(2'b01, 12'h300, 32'hFFFF_FFFF); tick();
    csr(2'b10, 12'h300, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h1888) begin err_cnt++;
      $display("FAIL mstatus_mask got=%h exp=%h", bus.csr_rdata, 32'h1888); end
    csr(2'b11, 12'h300, 32'h80); tick();
    idle();
    trap_valid = 1; trap_cause = 32'd11; trap_pc = 32'h8000_0102; trap_tval = 32'h0;
    tick();
    idle();
    vec_cnt++; if (mepc !== 32'h8000_0100) begin err_cnt++;
      $display("FAIL trap_mepc got=%h exp=%h", mepc, 32'h8000_0100); end
    csr(2'b10, 12'h342, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'd11) begin err_cnt++;
      $display("FAIL trap_mcause got=%h exp=%h", bus.csr_rdata, 32'd11); end
    csr(2'b10, 12'h300, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h1880) begin err_cnt++;
      $display("FAIL trap_mstatus got=%h exp=%h", bus.csr_rdata, 32'h1880); end
    idle(); mret = 1; tick(); idle();
    csr(2'b10, 12'h300, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h1888) begin err_cnt++;
      $display("FAIL mret_mstatus got=%h exp=%h", bus.csr_rdata, 32'h1888); end
    idle(); tick();
  endtask

  task automatic test_vectored();
    csr(2'b01, 12'h305, 32'h8000_1003); tick(); idle();
    csr(2'b10, 12'h305, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h8000_1001) begin err_cnt++;
      $display("FAIL mtvec_mask got=%h exp=%h", bus.csr_rdata, 32'h8000_1001); end
    idle();
    trap_cause = 32'h8000_0007; #1;
    vec_cnt++; if (trap_target !== 32'h8000_101C) begin err_cnt++;
      $display("FAIL vec_irq_target got=%h exp=%h", trap_target, 32'h8000_101C); end
    trap_cause = 32'd2; #1;
    vec_cnt++; if (trap_target !== 32'h8000_1000) begin err_cnt++;
      $display("FAIL vec_exc_target got=%h exp=%h", trap_target, 32'h8000_1000); end
    csr(2'b01, 12'h305, 32'h8000_2000); tick(); idle();
    trap_cause = 32'h8000_0007; #1;
    vec_cnt++; if (trap_target !== 32'h8000_2000) begin err_cnt++;
      $display("FAIL direct_target got=%h exp=%h", trap_target, 32'h8000_2000); end
    idle(); tick();
  endtask

  task automatic test_irq();
    irq_timer = 0; irq_ext = 0;
    csr(2'b01, 12'h304, 32'hFFFF_FFFF); tick();
    csr(2'b01, 12'h300, 32'h8); tick(); idle();
    csr(2'b10, 12'h304, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h880) begin err_cnt++;
      $display("FAIL mie_mask got=%h exp=%h", bus.csr_rdata, 32'h880); end
    idle(); tick();
    irq_timer = 1; #1;
    vec_cnt++; if (irq_req !== 1'b0) begin err_cnt++;
      $display("FAIL irq_n0 got=%b exp=0", irq_req); end
    tick();
    vec_cnt++; if (irq_req !== 1'b0) begin err_cnt++;
      $display("FAIL irq_n1 got=%b exp=0", irq_req); end
    tick();
    vec_cnt++; if (irq_req !== 1'b1 || irq_cause !== 32'h8000_0007) begin err_cnt++;
      $display("FAIL irq_n2 got=%b/%h exp=1/%h", irq_req, irq_cause, 32'h8000_0007); end
    irq_ext = 1; tick(); tick();
    vec_cnt++; if (irq_req !== 1'b1 || irq_cause !== 32'h8000_000B) begin err_cnt++;
      $display("FAIL irq_ext got=%b/%h exp=1/%h", irq_req, irq_cause, 32'h8000_000B); end
    csr(2'b11, 12'h300, 32'h8); tick(); idle(); tick();
    vec_cnt++; if (irq_req !== 1'b0) begin err_cnt++;
      $display("FAIL irq_mie_clear got=%b exp=0", irq_req); end
    csr(2'b10, 12'h300, 32'h8); tick(); idle(); tick();
    vec_cnt++; if (irq_req !== 1'b1) begin err_cnt++;
      $display("FAIL irq_mie_set got=%b exp=1", irq_req); end
    trap_valid = 1; trap_cause = 32'h8000_000B; tick(); idle();
    vec_cnt++; if (irq_req !== 1'b0) begin err_cnt++;
      $display("FAIL irq_trap_force got=%b exp=0", irq_req); end
    irq_timer = 0; irq_ext = 0;
    csr(2'b01, 12'h304, 32'h0); tick(); idle(); tick();
  endtask

  task automatic test_illegal_priority();
    csr(2'b01, 12'h340, 32'h1234_5678); tick();
    csr(2'b01, 12'hF14, 32'hFFFF); #1;
    vec_cnt++; if (bus.csr_illegal !== 1'b1 || bus.csr_rdata !== HART) begin err_cnt++;
      $display("FAIL ill_hartid got=%b/%h exp=1/%h", bus.csr_illegal, bus.csr_rdata, HART); end
    tick();
    csr(2'b01, 12'h7C0, 32'hFFFF); #1;
    vec_cnt++; if (bus.csr_illegal !== 1'b1 || bus.csr_rdata !== 32'h0) begin err_cnt++;
      $display("FAIL ill_unimpl got=%b/%h exp=1/0", bus.csr_illegal, bus.csr_rdata); end
    tick();
    csr(2'b11, 12'h344, 32'hFFFF); #1;
    vec_cnt++; if (bus.csr_illegal !== 1'b1) begin err_cnt++;
      $display("FAIL ill_mip got=%b exp=1", bus.csr_illegal); end
    tick();
    csr(2'b10, 12'h340, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h1234_5678) begin err_cnt++;
      $display("FAIL ill_no_change got=%h exp=%h", bus.csr_rdata, 32'h1234_5678); end
    csr(2'b10, 12'hF14, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== HART) begin err_cnt++;
      $display("FAIL ill_hartid_kept got=%h exp=%h", bus.csr_rdata, HART); end
    csr(2'b01, 12'h300, 32'h8); tick();
    csr(2'b01, 12'h341, 32'h1234);
    trap_valid = 1; trap_cause = 32'd2; trap_pc = 32'h40; trap_tval = 32'h77; #1;
    vec_cnt++; if (bus.csr_illegal !== 1'b0) begin err_cnt++;
      $display("FAIL prio_legal got=%b exp=0", bus.csr_illegal); end
    tick(); idle();
    vec_cnt++; if (mepc !== 32'h40) begin err_cnt++;
      $display("FAIL prio_mepc got=%h exp=%h", mepc, 32'h40); end
    csr(2'b01, 12'h300, 32'h0); mret = 1; tick(); idle();
    csr(2'b10, 12'h300, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h1888) begin err_cnt++;
      $display("FAIL prio_mret got=%h exp=%h", bus.csr_rdata, 32'h1888); end
    csr(2'b01, 12'hF14, 32'h1); trap_valid = 1; trap_pc = 32'h80; #1;
    vec_cnt++; if (bus.csr_illegal !== 1'b1) begin err_cnt++;
      $display("FAIL prio_ill_reported got=%b exp=1", bus.csr_illegal); end
    tick(); idle(); tick();
  endtask

  task automatic test_counter();
`ifdef YSYX_CSR_COUNTER_EN
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF); tick(); idle(); tick();
    csr(2'b10, 12'hB80, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h1 || bus.csr_illegal !== 1'b0) begin err_cnt++;
      $display("FAIL mcycleh got=%h/%b exp=1/0", bus.csr_rdata, bus.csr_illegal); end
    tick();
    csr(2'b10, 12'hB00, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h0) begin err_cnt++;
      $display("FAIL mcycle_low got=%h exp=0", bus.csr_rdata); end
    csr(2'b01, 12'hB02, 32'h5); tick(); idle();
    instret_inc = 1; tick(); tick(); tick(); instret_inc = 0;
    csr(2'b10, 12'hB02, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h8) begin err_cnt++;
      $display("FAIL minstret got=%h exp=8", bus.csr_rdata); end
`else
    csr(2'b10, 12'hB00, 32'h0); #1;
    vec_cnt++; if (bus.csr_illegal !== 1'b1 || bus.csr_rdata !== 32'h0) begin err_cnt++;
      $display("FAIL nocnt_mcycle got=%b/%h exp=1/0", bus.csr_illegal, bus.csr_rdata); end
    csr(2'b01, 12'hB82, 32'h1); #1;
    vec_cnt++; if (bus.csr_illegal !== 1'b1 || bus.csr_rdata !== 32'h0) begin err_cnt++;
      $display("FAIL nocnt_minstreth got=%b/%h exp=1/0", bus.csr_illegal, bus.csr_rdata); end
`endif
    idle(); tick();
  endtask

  task automatic test_mid_reset();
    csr(2'b01, 12'h340, 32'hAAAA_5555); tick();
    csr(2'b01, 12'h300, 32'h88); tick();
    csr(2'b01, 12'h340, 32'h1); trap_valid = 1; trap_pc = 32'h100; rst_n = 0;
    tick();
    rst_n = 1; idle();
    csr(2'b10, 12'h340, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h0) begin err_cnt++;
      $display("FAIL midrst_mscratch got=%h exp=0", bus.csr_rdata); end
    csr(2'b10, 12'h300, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h1800 || mepc !== 32'h0) begin err_cnt++;
      $display("FAIL midrst_mstatus got=%h/%h exp=1800/0", bus.csr_rdata, mepc); end
`ifdef YSYX_CSR_COUNTER_EN
    csr(2'b10, 12'hB00, 32'h0); #1;
    vec_cnt++; if (bus.csr_rdata !== 32'h0) begin err_cnt++;
      $display("FAIL midrst_mcycle got=%h exp=0", bus.csr_rdata); end
`endif
    idle(); tick();
  endtask

  task automatic test_random();
    logic [11:0] addrs [16];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
              12'hF14, 12'h7C0, 12'h301, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11};
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      bus.csr_op = 2'($urandom_range(0, 3));
      bus.csr_addr = addrs[$urandom_range(0, 15)];
      bus.csr_wdata = ($urandom_range(0, 1) != 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
      trap_valid = ($urandom_range(0, 9) == 0);
      mret = ($urandom_range(0, 9) == 0);
      instret_inc = 1'($urandom_range(0, 1));
      trap_cause = {1'($urandom_range(0, 1)), 27'd0, 4'($urandom_range(0, 15))};
      trap_pc = $urandom; trap_tval = $urandom;
      if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
      #1;
      vec_cnt++; if (bus.csr_rdata !== m_rdata()) begin err_cnt++;
        $display("FAIL rand_rdata i=%0d addr=%h op=%0d got=%h exp=%h", i, bus.csr_addr,
                 bus.csr_op, bus.csr_rdata, m_rdata()); end
      vec_cnt++; if (bus.csr_illegal !== m_illegal()) begin err_cnt++;
        $display("FAIL rand_illegal i=%0d addr=%h got=%b exp=%b", i, bus.csr_addr,
                 bus.csr_illegal, m_illegal()); end
      vec_cnt++; if (trap_target !== m_target()) begin err_cnt++;
        $display("FAIL rand_target i=%0d got=%h exp=%h", i, trap_target, m_target()); end
      vec_cnt++; if (mepc !== (m_mepc & ~32'h3)) begin err_cnt++;
        $display("FAIL rand_mepc i=%0d got=%h exp=%h", i, mepc, m_mepc & ~32'h3); end
      vec_cnt++; if (irq_req !== m_irq) begin err_cnt++;
        $display("FAIL rand_irq_req i=%0d got=%b exp=%b", i, irq_req, m_irq); end
      if (m_irq) begin
        vec_cnt++; if (irq_cause !== m_irq_cause) begin err_cnt++;
          $display("FAIL rand_irq_cause i=%0d got=%h exp=%h", i, irq_cause, m_irq_cause); end
      end
      tick();
    end
    rst_n = 1; idle(); tick();
  endtask

  initial begin
    idle();
    irq_timer = 0; irq_ext = 0; rst_n = 0;
    test_reset();
    test_write_read();
    test_trap_mret();
    test_vectored();
    test_irq();
    test_illegal_priority();
    test_counter();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
